// File: rtl/proj_pkg.sv
// Shared types and default constants for the projectile pool and its slots.
package proj_pkg;

    // Life cycle of a single projectile slot.
    typedef enum logic {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } proj_state_e;

    // Trigger arming: a held trigger must be released before it can fire again.
    typedef enum logic {
        ARMED        = 1'b0,
        WAIT_RELEASE = 1'b1
    } arm_state_e;

    // Default horizontal screen limits, inclusive.
    localparam int X_MIN_DEF   = 0;
    localparam int X_MAX_DEF   = 639;
    localparam int COORD_W_DEF = 10;

    // Snapshot of one slot at the default coordinate width.
    typedef struct packed {
        proj_state_e            state;
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
    } slot_t;

endpackage

// File: rtl/proj_slot.sv
// One projectile slot: flight state, horizontal motion with bounds retirement,
// contact retirement and the pixel-inside-projectile compare.
module proj_slot
    import proj_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int PROJ_HALF = 4,
    parameter int X_MIN     = X_MIN_DEF,
    parameter int X_MAX     = X_MAX_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               tick,
    input  logic               contact,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] x_step,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    output logic               active,
    output logic               free,
    output logic               hit,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam int SW = COORD_W + 1;
    localparam int PW = ((COORD_W > 10) ? COORD_W : 10) + 1;

    proj_state_e          state;
    proj_state_e          state_next;
    logic [COORD_W-1:0]   x_next;
    logic [COORD_W-1:0]   y_next;
    logic signed [SW-1:0] sum;
    logic                 out_of_bounds;
    logic signed [PW-1:0] dx;
    logic signed [PW-1:0] dy;
    logic [PW-1:0]        adx;
    logic [PW-1:0]        ady;

    // Position is unsigned, velocity is two's complement; one extra bit keeps both honest.
    assign sum           = $signed({1'b0, x}) + $signed({x_step[COORD_W-1], x_step});
    assign out_of_bounds = (sum < $signed(SW'(X_MIN))) || (sum > $signed(SW'(X_MAX)));

    assign active = (state == FLYING);
    // Free for a spawn this cycle if already idle or retiring right now.
    assign free   = !active || contact || (tick && out_of_bounds);

    // Next slot state: spawn wins, then contact, then motion on the frame tick.
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        if (spawn) begin
            state_next = FLYING;
            x_next     = spawn_x;
            y_next     = spawn_y;
        end else if (state == FLYING) begin
            if (contact) begin
                state_next = IDLE;
            end else if (tick) begin
                if (out_of_bounds) begin
                    state_next = IDLE;
                end else begin
                    x_next = sum[COORD_W-1:0];
                end
            end
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
        end
    end

    // Square hit region around the centre, distances taken as signed differences.
    assign dx  = $signed(PW'(draw_x)) - $signed(PW'(x));
    assign dy  = $signed(PW'(draw_y)) - $signed(PW'(y));
    assign adx = dx[PW-1] ? (~dx + 1'b1) : dx;
    assign ady = dy[PW-1] ? (~dy + 1'b1) : dy;
    assign hit = active && (adx < PW'(PROJ_HALF)) && (ady < PW'(PROJ_HALF));

endmodule

// File: rtl/projectile_pool.sv
// Pool of projectile slots for one shooter: frame tick detection, fire
// cooldown, trigger arming, free-slot selection and output packing.
// Define PROJ_AUTOFIRE_EN to bypass arming so a held trigger keeps firing.
module projectile_pool
    import proj_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COORD_W         = 10,
    parameter int PROJ_HALF       = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int X_MIN           = X_MIN_DEF,
    parameter int X_MAX           = X_MAX_DEF,
    localparam int SLOT_W         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic                         activate,
    input  logic [COORD_W-1:0]           Shooter_X,
    input  logic [COORD_W-1:0]           Shooter_Y,
    input  logic [COORD_W-1:0]           X_Step,
    input  logic [NUM_SLOTS-1:0]         contact,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   DrawY,
    output logic [NUM_SLOTS*COORD_W-1:0] Proj_X_Curr_Pos,
    output logic [NUM_SLOTS*COORD_W-1:0] Proj_Y_Curr_Pos,
    output logic [NUM_SLOTS-1:0]         active,
    output logic                         is_proj,
    output logic [SLOT_W-1:0]            proj_slot,
    output logic                         fired
);

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic                 fc_d;
    logic                 tick;
    logic [CD_W-1:0]      cooldown;
    arm_state_e           arm_state;
    arm_state_e           arm_next;
    logic [NUM_SLOTS-1:0] slot_free;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic [NUM_SLOTS-1:0] spawn;
    logic                 accept;

    assign tick = frame_clk & ~fc_d;

    // Delay the vertical sync by one clock for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_d <= 1'b0;
        end else begin
            fc_d <= frame_clk;
        end
    end

    // Lowest set bit of the free mask picks the slot a new shot lands in.
    assign spawn_sel = slot_free & (~slot_free + 1'b1);
    assign accept    = tick && activate && (arm_state == ARMED) &&
                       (cooldown == '0) && (|slot_free);
    assign spawn     = accept ? spawn_sel : '0;

    // Cooldown reloads on an accepted shot, otherwise counts frames down to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cooldown <= '0;
            fired    <= 1'b0;
        end else begin
            fired <= accept;
            if (tick) begin
                if (accept) begin
                    cooldown <= CD_W'(COOLDOWN_FRAMES);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end
            end
        end
    end

    // Arming state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            arm_state <= ARMED;
        end else begin
            arm_state <= arm_next;
        end
    end

    // Arming transitions: a shot disarms until a frame sees the trigger released.
    always_comb begin
        arm_next = arm_state;
`ifdef PROJ_AUTOFIRE_EN
        arm_next = ARMED;
`else
        case (arm_state)
            ARMED:        if (accept) arm_next = WAIT_RELEASE;
            WAIT_RELEASE: if (tick && !activate) arm_next = ARMED;
            default:      arm_next = ARMED;
        endcase
`endif
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        proj_slot #(
            .COORD_W  (COORD_W),
            .PROJ_HALF(PROJ_HALF),
            .X_MIN    (X_MIN),
            .X_MAX    (X_MAX)
        ) u_slot (
            .Clk    (Clk),
            .Reset  (Reset),
            .tick   (tick),
            .contact(contact[i]),
            .spawn  (spawn[i]),
            .spawn_x(Shooter_X),
            .spawn_y(Shooter_Y),
            .x_step (X_Step),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .active (active[i]),
            .free   (slot_free[i]),
            .hit    (slot_hit[i]),
            .x      (Proj_X_Curr_Pos[i*COORD_W +: COORD_W]),
            .y      (Proj_Y_Curr_Pos[i*COORD_W +: COORD_W])
        );
    end

    assign is_proj = |slot_hit;

    // Report the lowest-index slot under the current pixel; scanning downward leaves it last.
    always_comb begin
        proj_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) proj_slot = SLOT_W'(i);
        end
    end

endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool against a frame-level behavioural model.
module tb_projectile_pool;

    localparam int N    = 4;
    localparam int COOL = 15;
    localparam int HALF = 4;
    localparam int XMIN = 0;
    localparam int XMAX = 639;
`ifdef PROJ_AUTOFIRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset;
    logic         frame_clk;
    logic         activate;
    logic [9:0]   Shooter_X;
    logic [9:0]   Shooter_Y;
    logic [9:0]   X_Step;
    logic [N-1:0] contact;
    logic [9:0]   DrawX;
    logic [9:0]   DrawY;
    logic [39:0]  Proj_X_Curr_Pos;
    logic [39:0]  Proj_Y_Curr_Pos;
    logic [N-1:0] active;
    logic         is_proj;
    logic [1:0]   proj_slot;
    logic         fired;

    int n_assert = 0;
    int n_fail   = 0;
    int fired_seen = 0;
    int fired_model = 0;
    int snap;

    int m_x[N];
    int m_y[N];
    bit m_act[N];
    int m_cd;
    bit m_wait;
    bit m_fcd;
    bit m_fired;

    projectile_pool dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .activate       (activate),
        .Shooter_X      (Shooter_X),
        .Shooter_Y      (Shooter_Y),
        .X_Step         (X_Step),
        .contact        (contact),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .Proj_X_Curr_Pos(Proj_X_Curr_Pos),
        .Proj_Y_Curr_Pos(Proj_Y_Curr_Pos),
        .active         (active),
        .is_proj        (is_proj),
        .proj_slot      (proj_slot),
        .fired          (fired)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model, applying the rules at frame granularity.
    task automatic modelClock();
        bit tick;
        bit accepted;
        int step;
        int nx;
        int pick;
        tick    = frame_clk && !m_fcd;
        m_fired = 1'b0;
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0;
            end
            m_cd = 0; m_wait = 1'b0; m_fcd = 1'b0;
            return;
        end
        m_fcd = frame_clk;
        for (int i = 0; i < N; i++) if (contact[i]) m_act[i] = 1'b0;
        if (tick) begin
            step = int'($signed(X_Step));
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    nx = m_x[i] + step;
                    if (nx < XMIN || nx > XMAX) m_act[i] = 1'b0;
                    else m_x[i] = nx;
                end
            end
            accepted = 1'b0;
            if (activate && !m_wait && m_cd == 0) begin
                pick = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_act[i]) pick = i;
                if (pick >= 0) begin
                    m_act[pick] = 1'b1;
                    m_x[pick]   = int'(Shooter_X);
                    m_y[pick]   = int'(Shooter_Y);
                    accepted    = 1'b1;
                end
            end
            if (accepted) begin
                m_cd   = COOL;
                m_wait = !AUTO;
            end else if (m_cd > 0) begin
                m_cd--;
            end
            if (!activate) m_wait = 1'b0;
            m_fired = accepted;
        end
    endtask

    task automatic checkOutput();
        logic [39:0]  ex;
        logic [39:0]  ey;
        logic [N-1:0] ea;
        logic         ep;
        logic [1:0]   es;
        int           dx;
        int           dy;
        ep = 1'b0; es = 2'd0;
        for (int i = 0; i < N; i++) begin
            ex[i*10 +: 10] = 10'(m_x[i]);
            ey[i*10 +: 10] = 10'(m_y[i]);
            ea[i]          = m_act[i];
            dx = int'(DrawX) - m_x[i];
            dy = int'(DrawY) - m_y[i];
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (!ep && m_act[i] && dx < HALF && dy < HALF) begin
                ep = 1'b1; es = 2'(i);
            end
        end
        if (fired === 1'b1) fired_seen++;
        if (m_fired) fired_model++;
        chk("active", 64'(active), 64'(ea));
        chk("fired", 64'(fired), 64'(m_fired));
        chk("pos_x", 64'(Proj_X_Curr_Pos), 64'(ex));
        chk("pos_y", 64'(Proj_Y_Curr_Pos), 64'(ey));
        chk("is_proj", 64'(is_proj), 64'(ep));
        chk("proj_slot", 64'(proj_slot), 64'(es));
    endtask

    task automatic applyStimulus(input logic fc, input logic act, input logic [N-1:0] con,
                                 input logic rst);
        int idx;
        frame_clk = fc;
        activate  = act;
        contact   = con;
        Reset     = rst;
        idx   = $urandom_range(0, N - 1);
        DrawX = 10'(m_x[idx] + int'($urandom_range(0, 10)) - 5);
        DrawY = 10'(m_y[idx] + int'($urandom_range(0, 10)) - 5);
        @(posedge Clk);
        modelClock();
        #1;
        checkOutput();
    endtask

    task automatic frame(input logic act, input int gap);
        applyStimulus(1'b1, act, '0, 1'b0);
        repeat (gap) applyStimulus(1'b0, act, '0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; activate = 1'b0; contact = '0;
        Shooter_X = '0; Shooter_Y = '0; X_Step = '0; DrawX = '0; DrawY = '0;
        m_fcd = 1'b0; m_cd = 0; m_wait = 1'b0; m_fired = 1'b0;
        for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0; end

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_fired", 64'(fired), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        $display("[TB] single shot");
        Shooter_X = 10'd285; Shooter_Y = 10'd379; X_Step = 10'd4;
        frame(1'b1, 1);
        chk("spawn_x", 64'(Proj_X_Curr_Pos[9:0]), 64'd285);
        chk("spawn_act", 64'(active), 64'b0001);
        repeat (3) frame(1'b0, 2);
        chk("x297", 64'(Proj_X_Curr_Pos[9:0]), 64'd297);
        chk("y379", 64'(Proj_Y_Curr_Pos[9:0]), 64'd379);

        $display("[TB] contact");
        applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0);
        chk("contact_ret", 64'(active[0]), 64'd0);
        repeat (12) frame(1'b0, 1);
        Shooter_X = 10'd100; Shooter_Y = 10'd200;
        frame(1'b1, 1);
        chk("reuse_slot0", 64'(Proj_X_Curr_Pos[9:0]), 64'd100);

        $display("[TB] right bound");
        repeat (15) frame(1'b0, 1);
        Shooter_X = 10'd620; Shooter_Y = 10'd50;
        frame(1'b1, 1);
        repeat (4) frame(1'b0, 1);
        chk("x636", 64'(Proj_X_Curr_Pos[19:10]), 64'd636);
        frame(1'b0, 1);
        chk("right_ret", 64'(active[1]), 64'd0);
        chk("right_hold", 64'(Proj_X_Curr_Pos[19:10]), 64'd636);

        $display("[TB] left bound");
        repeat (10) frame(1'b0, 1);
        X_Step = 10'h3FC; Shooter_X = 10'd10; Shooter_Y = 10'd60;
        frame(1'b1, 1);
        frame(1'b0, 1);
        frame(1'b0, 1);
        chk("x2", 64'(Proj_X_Curr_Pos[19:10]), 64'd2);
        frame(1'b0, 1);
        chk("left_ret", 64'(active[1]), 64'd0);

        $display("[TB] trigger hold");
        repeat (12) frame(1'b0, 1);
        X_Step = 10'd1;
        snap = fired_seen;
        repeat (60) frame(1'b1, 1);
`ifndef PROJ_AUTOFIRE_EN
        chk("semi_one", 64'(fired_seen - snap), 64'd1);
        frame(1'b0, 1);
        snap = fired_seen;
        frame(1'b1, 1);
        chk("semi_second", 64'(fired_seen - snap), 64'd1);
`endif

        $display("[TB] pool full");
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        X_Step = 10'd0;
        for (int k = 0; k < N; k++) begin
            Shooter_X = 10'($urandom_range(0, 639)); Shooter_Y = 10'($urandom_range(0, 479));
            frame(1'b1, 1);
            repeat (16) frame(1'b0, 1);
        end
        chk("full", 64'(active), 64'b1111);
        snap = fired_seen;
        frame(1'b1, 1);
        chk("full_drop", 64'(fired_seen - snap), 64'd0);

        $display("[TB] reset in flight");
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            frame(1'b1, 1);
            repeat ((k == 2) ? 8 : 16) frame(1'b0, 1);
        end
        applyStimulus(1'b1, 1'b1, '0, 1'b1);
        chk("rst_flight", 64'(active), 64'd0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        frame(1'b1, 1);
        chk("post_rst_fire", 64'(active), 64'b0001);

        $display("[TB] random");
        for (int f = 0; f < 80; f++) begin
            X_Step    = 10'($urandom_range(0, 12) - 6);
            Shooter_X = 10'($urandom_range(0, 639));
            Shooter_Y = 10'($urandom_range(0, 479));
            activate  = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, activate,
                          ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0,
                          ($urandom_range(0, 40) == 0));
            repeat ($urandom_range(1, 3))
                applyStimulus(1'b0, activate,
                              ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0, 1'b0);
        end
        chk("fired_total", 64'(fired_seen), 64'(fired_model));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/projectile_pool.md
# projectile_pool

Multi-slot projectile manager: replaces the single-bullet-per-shooter projectile with a pool of NUM_SLOTS independent projectiles per shooter. Supports frame-rate motion, fire cooldown, per-slot contact retirement and off-screen retirement. One instance per shooter (player, NPC) sits between input/stage logic, the hitbox comparators and color_mapper; it exports slot positions and a pixel-hit flag.

## Interface
- NUM_SLOTS, 4: projectile slots; 1..8.
- COORD_W, 10: coordinate width.
- PROJ_HALF, 4: projectile half-size in pixels; square hit region.
- COOLDOWN_FRAMES, 15: frames between accepted shots; 0 disables cooldown.
- X_MIN, 0 / X_MAX, 639: inclusive on-screen X bounds.
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  VGA_VS; rising edge = frame tick.
- activate  in  1  fire request (level).
- Shooter_X, Shooter_Y  in  COORD_W  shooter centre; spawn point.
- X_Step  in  COORD_W  signed two's-complement X velocity, pixels/frame.
- contact  in  NUM_SLOTS  per-slot hit from hitbox comparators.
- DrawX, DrawY  in  10  current pixel.
- Proj_X_Curr_Pos, Proj_Y_Curr_Pos  out  NUM_SLOTS*COORD_W  packed slot positions; slot i at [i*COORD_W +: COORD_W].
- active  out  NUM_SLOTS  slot in flight.
- is_proj  out  1  DrawX/DrawY inside any active slot.
- proj_slot  out  $clog2(NUM_SLOTS) (min 1)  lowest-index slot hit by pixel.
- fired  out  1  one-Clk pulse when a shot is accepted.

## Operation
- Frame tick: frame_clk registered into fc_d; tick = frame_clk & ~fc_d. One Clk wide. After reset, fc_d = 0.
- Per-slot FSM: IDLE -> FLYING on spawn; FLYING -> IDLE on contact or out-of-bounds; IDLE otherwise holds.
- Contact: contact[i] while active[i] -> slot i IDLE at next Clk edge, any cycle, not only on tick. Contact on an IDLE slot is ignored.
- Motion on tick: every FLYING slot not contacted this cycle: X <= X + X_Step. Sum computed in COORD_W+1 signed (X zero-extended, X_Step sign-extended). If result < X_MIN or > X_MAX, the slot goes IDLE; its X is left unchanged. Y never changes in flight.
- Fire on tick: accepted iff (fire armed) & cooldown==0 & at least one slot is IDLE after this cycle's retirements. The lowest-index such slot loads (Shooter_X, Shooter_Y) and goes FLYING. It is not moved on the spawn tick. cooldown <= COOLDOWN_FRAMES; fired pulses with the load.
- Shot with pool full: dropped. Cooldown is not reloaded. No fired pulse.
- Cooldown: decrements by 1 on each tick, saturating at 0. The reload on an accepting tick overrides the decrement.
- Arming (see Configuration): arm FSM ARMED / WAIT_RELEASE.
- Simultaneous: contact and out-of-bounds on the same slot -> IDLE, single retirement. A slot freed by contact in the tick cycle is reusable in that same tick.
- Pixel: is_proj = OR over active i of (|DrawX − X_i| < PROJ_HALF and |DrawY − Y_i| < PROJ_HALF). Differences are taken unsigned-safe via COORD_W+1 signed. proj_slot = lowest such i, else 0.

## Timing
- Reset values: all slots IDLE, positions 0, active=0, cooldown=0, arm=ARMED, fired=0, fc_d=0. is_proj=0 follows from active=0.
- Reset mid-flight clears everything at the next edge; a tick coincident with Reset is ignored.
- Latencies:
  - tick detection: 1 Clk after the frame_clk rise.
  - spawn: active visible 1 Clk after tick.
  - contact retirement: 1 Clk.
- Pixel path is purely combinational from DrawX/DrawY and registered slot state; 0 latency, matching color_mapper's same-cycle use.
- Slot state changes only on Clk edges; outputs are glitch-free registers except is_proj and proj_slot.

## Configuration
- PROJ_AUTOFIRE_EN defined: arm FSM is bypassed (always ARMED). Holding activate fires every COOLDOWN_FRAMES+1 ticks while a slot is free.
- Undefined (semi-auto): each accepted shot moves arm to WAIT_RELEASE. It returns to ARMED on the first tick with activate=0. Holding activate yields exactly one shot.

## Structure
- proj_pkg:
  - proj_state_e (IDLE, FLYING)
  - arm_state_e (ARMED, WAIT_RELEASE)
  - slot_t struct {state, x, y}
  - default bounds constants X_MIN_DEF, X_MAX_DEF
- Sub-module proj_slot: one slot's FSM, motion/bounds arithmetic and pixel-hit compare. It is instantiated NUM_SLOTS times via generate.
- projectile_pool owns tick detection, cooldown, arm FSM, free-slot priority encoder and output packing.

## Test plan
- Single shot: activate for one tick, Shooter=(285,379), X_Step=4 → slot0 FLYING at (285,379), fired pulse; after 3 more ticks X=297.
- Right bound: X_Step=4, slot at X=636 → next tick IDLE, X stays 636.
- Left bound: X_Step=−4 (10'h3FC), X=2 → next tick IDLE.
- Contact: contact[0]=1 mid-frame → active[0]=0 next Clk; a shot on the following tick reuses slot0.
- Pool full / cooldown: NUM_SLOTS=2, COOLDOWN_FRAMES=0, autofire, slots stay in flight → shots 1–2 accepted; 3rd tick no fired, no slot change. COOLDOWN_FRAMES=15 → shots spaced exactly 16 ticks.
- Semi-auto (macro undefined): activate held 60 frames → exactly one fired. Release one tick, press again → second shot.
- Reset while 3 slots FLYING and cooldown=7 → next edge active=0, cooldown=0. Fire on the first post-reset tick is accepted.
